// File: rtl/load_store_unit.sv
// Data-memory load/store unit: accepts one load or store at a time, waits a fixed
// number of memory wait states, then reports the extended result for one cycle.
module load_store_unit #(
  parameter int unsigned MEM_WORDS   = 64,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] instruction,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rd_data,
  output logic        done,
  output logic        err
);

  localparam int unsigned AW        = $clog2(MEM_WORDS);
  localparam logic [6:0]  OP_LOAD   = 7'b0000011;
  localparam logic [6:0]  OP_STORE  = 7'b0100011;
  localparam logic [3:0]  WAIT_INIT = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q;
  logic        is_store_q;
  logic [2:0]  f3_q;
  logic [31:0] addr_q, wdata_q;
  logic [31:0] rd_q;
  logic        err_q;

  logic        is_load_op, is_store_op, accept, enter_done;
  logic        cur_store;
  logic [2:0]  cur_f3;
  logic [31:0] cur_addr, cur_wdata;
  logic [AW-1:0] widx;
  logic [31:0] mem_word, shifted, load_val, st_word, merged;
  logic [15:0] half;
  logic [3:0]  be;
  logic        bad, mem_we;
  logic        unused_bits;

  logic [31:0] mem [MEM_WORDS] = '{default: '0};

  assign unused_bits = ^{instruction[31:15], instruction[11:7], addr_q[31:AW+2], addr[31:AW+2]};

  assign is_load_op  = (instruction[6:0] == OP_LOAD);
  assign is_store_op = (instruction[6:0] == OP_STORE);
  assign accept      = req_valid && (state_q == S_IDLE) && (is_load_op || is_store_op);

  // With zero wait states the access resolves on the acceptance edge itself,
  // so the live request fields are used while IDLE instead of the latched copy.
  always_comb begin
    if (state_q == S_IDLE) begin
      cur_store = is_store_op;
      cur_f3    = instruction[14:12];
      cur_addr  = addr;
      cur_wdata = wdata;
    end else begin
      cur_store = is_store_q;
      cur_f3    = f3_q;
      cur_addr  = addr_q;
      cur_wdata = wdata_q;
    end
  end

  always_comb begin
    state_d    = state_q;
    enter_done = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (WAIT_CYCLES == 0) begin
            state_d    = S_DONE;
            enter_done = 1'b1;
          end else begin
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d    = S_DONE;
          enter_done = 1'b1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      is_store_q <= 1'b0;
      f3_q       <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rd_q       <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        cnt_q      <= WAIT_INIT;
        is_store_q <= is_store_op;
        f3_q       <= instruction[14:12];
        addr_q     <= addr;
        wdata_q    <= wdata;
      end else if ((state_q == S_WAIT) && (cnt_q != 4'd0)) begin
        cnt_q <= cnt_q - 4'd1;
      end
      if (enter_done) begin
        rd_q  <= (cur_store || bad) ? '0 : load_val;
        err_q <= bad;
      end
    end
  end

  always_comb begin
    bad = 1'b0;
    if (cur_store) begin
      case (cur_f3)
        3'b000:  bad = 1'b0;
        3'b001:  bad = cur_addr[0];
        3'b010:  bad = |cur_addr[1:0];
        default: bad = 1'b1;
      endcase
    end else begin
      case (cur_f3)
        3'b000, 3'b100: bad = 1'b0;
        3'b001, 3'b101: bad = cur_addr[0];
        3'b010:         bad = |cur_addr[1:0];
        default:        bad = 1'b1;
      endcase
    end
  end

  assign widx     = cur_addr[AW+1:2];
  assign mem_word = mem[widx];
  assign shifted  = mem_word >> {cur_addr[1:0], 3'b000};
  assign half     = cur_addr[1] ? mem_word[31:16] : mem_word[15:0];

  always_comb begin
    case (cur_f3)
      3'b000:  load_val = {{24{shifted[7]}}, shifted[7:0]};
      3'b001:  load_val = {{16{half[15]}}, half};
      3'b010:  load_val = mem_word;
      3'b100:  load_val = {24'd0, shifted[7:0]};
      3'b101:  load_val = {16'd0, half};
      default: load_val = '0;
    endcase
  end

  always_comb begin
    st_word = cur_wdata;
    be      = 4'b1111;
    case (cur_f3[1:0])
      2'b00: begin
        st_word = {4{cur_wdata[7:0]}};
        be      = 4'b0001 << cur_addr[1:0];
      end
      2'b01: begin
        st_word = {2{cur_wdata[15:0]}};
        be      = cur_addr[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        st_word = cur_wdata;
        be      = 4'b1111;
      end
    endcase
    merged = mem_word;
    for (int unsigned i = 0; i < 4; i++) begin
      if (be[i]) merged[8*i +: 8] = st_word[8*i +: 8];
    end
  end

  // Memory is outside the reset domain; gating with reset keeps a request
  // presented during reset from writing when WAIT_CYCLES is zero.
  assign mem_we = reset && enter_done && cur_store && !bad;

  always_ff @(posedge clk) begin
    if (mem_we) mem[widx] <= merged;
  end

  assign req_ready = (state_q == S_IDLE);
  assign done      = (state_q == S_DONE);
  assign rd_data   = done ? rd_q : '0;
  assign err       = done && err_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench: two units (1 and 3 wait states) driven with directed and
// random accesses, checked against a byte-addressed memory model.
module tb_load_store_unit;

  logic        clk;
  logic        reset     [2];
  logic        req_valid [2];
  logic        req_ready [2];
  logic [31:0] instr     [2];
  logic [31:0] addr      [2];
  logic [31:0] wdata     [2];
  logic [31:0] rd_data   [2];
  logic        done      [2];
  logic        err       [2];

  int ntests = 0;
  int nfail  = 0;
  logic [7:0] mb [2][256];

  load_store_unit #(.MEM_WORDS(64), .WAIT_CYCLES(1)) u_dut1 (
    .clk(clk), .reset(reset[0]), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .instruction(instr[0]), .addr(addr[0]), .wdata(wdata[0]),
    .rd_data(rd_data[0]), .done(done[0]), .err(err[0]));

  load_store_unit #(.MEM_WORDS(64), .WAIT_CYCLES(3)) u_dut3 (
    .clk(clk), .reset(reset[1]), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .instruction(instr[1]), .addr(addr[1]), .wdata(wdata[1]),
    .rd_data(rd_data[1]), .done(done[1]), .err(err[1]));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model(input int d, input bit st, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] wd,
                       output logic [31:0] rd, output bit e);
    int b, sz;
    logic [31:0] v;
    b  = int'(a % 32'd256);
    sz = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    if (st) e = f3[2] || (f3[1:0] == 2'd3);
    else    e = (f3[1:0] == 2'd3) || (f3 == 3'b110);
    if (b % sz != 0) e = 1'b1;
    rd = '0;
    if (!e) begin
      if (st) begin
        for (int i = 0; i < sz; i++) mb[d][b+i] = wd[8*i +: 8];
      end else begin
        v = '0;
        for (int i = 0; i < sz; i++) v[8*i +: 8] = mb[d][b+i];
        if (!f3[2] && sz == 1) v = {{24{v[7]}}, v[7:0]};
        if (!f3[2] && sz == 2) v = {{16{v[15]}}, v[15:0]};
        rd = v;
      end
    end
  endtask

  // One request: present it, then keep a decoy store on the inputs while busy.
  task automatic access(input int d, input bit st, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] wd,
                        output logic [31:0] got);
    logic [31:0] erd;
    bit          eerr;
    int          wc;
    wc  = (d == 0) ? 1 : 3;
    got = '0;
    @(negedge clk);
    check("ready_idle", {31'd0, req_ready[d]}, 32'd1);
    instr[d]        = $urandom;
    instr[d][6:0]   = st ? 7'b0100011 : 7'b0000011;
    instr[d][14:12] = f3;
    addr[d]         = a;
    wdata[d]        = wd;
    req_valid[d]    = 1'b1;
    model(d, st, f3, a, wd, erd, eerr);
    @(posedge clk);
    #1;
    instr[d]      = $urandom;
    instr[d][6:0] = 7'b0100011;
    addr[d]       = $urandom;
    wdata[d]      = $urandom;
    for (int k = 1; k <= wc + 1; k++) begin
      @(negedge clk);
      if (k <= wc) begin
        check("done_busy", {31'd0, done[d]}, 32'd0);
        check("ready_busy", {31'd0, req_ready[d]}, 32'd0);
        check("rd_busy", rd_data[d], 32'd0);
      end else begin
        check("done_pulse", {31'd0, done[d]}, 32'd1);
        check("rd_data", rd_data[d], erd);
        check("err", {31'd0, err[d]}, {31'd0, eerr});
        got          = rd_data[d];
        req_valid[d] = 1'b0;
      end
    end
  endtask

  initial begin
    logic [31:0] g, ra;
    bit          rs;
    logic [2:0]  rf;
    for (int d = 0; d < 2; d++) begin
      reset[d] = 1'b0; req_valid[d] = 1'b0;
      instr[d] = '0; addr[d] = '0; wdata[d] = '0;
      for (int i = 0; i < 256; i++) mb[d][i] = 8'h00;
    end
    #2;
    for (int d = 0; d < 2; d++) begin
      check("rst_done", {31'd0, done[d]}, 32'd0);
      check("rst_err", {31'd0, err[d]}, 32'd0);
      check("rst_rd", rd_data[d], 32'd0);
    end
    @(negedge clk);
    @(negedge clk);
    reset[0] = 1'b1;
    reset[1] = 1'b1;

    // Non-memory opcode must be ignored.
    @(negedge clk);
    instr[0] = 32'h0000_0033; req_valid[0] = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("ign_ready", {31'd0, req_ready[0]}, 32'd1);
      check("ign_done", {31'd0, done[0]}, 32'd0);
    end
    req_valid[0] = 1'b0;

    access(0, 1, 3'b010, 32'h10, 32'hDEADBEEF, g);
    access(0, 0, 3'b010, 32'h10, 32'h0, g);        check("lw_10", g, 32'hDEADBEEF);
    access(0, 1, 3'b000, 32'h11, 32'h80, g);
    access(0, 0, 3'b000, 32'h11, 32'h0, g);        check("lb_11", g, 32'hFFFFFF80);
    access(0, 0, 3'b100, 32'h11, 32'h0, g);        check("lbu_11", g, 32'h00000080);
    access(0, 0, 3'b010, 32'h10, 32'h0, g);        check("lw_10b", g, 32'hDEAD80EF);
    access(0, 1, 3'b001, 32'h22, 32'h8001, g);
    access(0, 0, 3'b001, 32'h22, 32'h0, g);        check("lh_22", g, 32'hFFFF8001);
    access(0, 0, 3'b101, 32'h22, 32'h0, g);        check("lhu_22", g, 32'h00008001);
    access(0, 0, 3'b010, 32'h20, 32'h0, g);        check("lw_20", g, 32'h80010000);
    access(0, 0, 3'b010, 32'h13, 32'h0, g);        check("lw_mis", g, 32'h0);
    access(0, 1, 3'b001, 32'h05, 32'hFFFF, g);
    access(0, 0, 3'b011, 32'h08, 32'h0, g);
    access(0, 0, 3'b010, 32'h04, 32'h0, g);        check("sh_mis_nowr", g, 32'h0);
    access(0, 1, 3'b010, 32'h100, 32'h12345678, g);
    access(0, 0, 3'b010, 32'h0, 32'h0, g);         check("lw_wrap", g, 32'h12345678);

    for (int n = 0; n < 150; n++) begin
      rs = 1'($urandom_range(0, 1));
      rf = 3'($urandom_range(0, 7));
      ra = $urandom;
      ra[7:0] = 8'($urandom_range(0, 47));
      if ($urandom_range(0, 3) != 0) begin
        rf[2] = rs ? 1'b0 : rf[2];
        if (rf[1:0] == 2'd3) rf[1:0] = 2'd2;
        if (rf[1:0] == 2'd2) ra[1:0] = 2'd0;
        if (rf[1:0] == 2'd1) ra[0] = 1'b0;
      end
      access(0, rs, rf, ra, $urandom, g);
    end

    // Reset mid-WAIT aborts a store on the 3-wait-state unit.
    access(1, 1, 3'b010, 32'h40, 32'h11111111, g);
    @(negedge clk);
    instr[1] = 32'h0000_2023; addr[1] = 32'h40; wdata[1] = 32'h22222222; req_valid[1] = 1'b1;
    @(posedge clk);
    #1 req_valid[1] = 1'b0;
    @(posedge clk);
    #1 reset[1] = 1'b0;
    #1;
    check("abort_ready", {31'd0, req_ready[1]}, 32'd1);
    check("abort_rd", rd_data[1], 32'd0);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("abort_done", {31'd0, done[1]}, 32'd0);
      check("abort_err", {31'd0, err[1]}, 32'd0);
    end
    reset[1] = 1'b1;
    access(1, 0, 3'b010, 32'h40, 32'h0, g);        check("abort_lw", g, 32'h11111111);

    for (int n = 0; n < 40; n++) begin
      rs = 1'($urandom_range(0, 1));
      rf = 3'($urandom_range(0, 5));
      ra = {$urandom, 2'b00};
      ra[7:0] = 8'($urandom_range(0, 31));
      access(1, rs, rf, ra, $urandom, g);
    end

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
